fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the SM83 CPU core, directly upstream of the opcode decoder. Fetches bytes from the CPU memory bus at the program counter and resolves the 0xCB prefix. Gathers 8/16-bit immediates, then presents one complete instruction (opcode, prefix flag, immediate, length, PC) to the decoder over a valid/ready handshake. Accepts PC redirects from execute for jumps, calls, returns and interrupt vectors.

## Interface
- RESET_PC, 16'h0000, PC fetched first after reset.
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  out  1  byte read request; held with stable mem_addr until mem_ack.
- mem_addr  out  16  read address.
- mem_ack  in  1  read complete this cycle; mem_rdata valid.
- mem_rdata  in  8  read data.
- op_valid  out  1  instruction bundle valid.
- op_ready  in  1  decoder accepts bundle.
- opcode  out  8  opcode byte; for CB instructions, the byte after 0xCB.
- op_cb  out  1  instruction is CB-prefixed.
- op_imm  out  16  immediate, little-endian assembled; 8-bit immediate in [7:0], [15:8]=0.
- op_len  out  2  total bytes including prefix/immediates (1..3).
- op_pc  out  16  address of first byte of instruction.
- op_illegal  out  1  opcode is one of D3,DB,DD,E3,E4,EB,EC,ED,F4,FC,FD.
- redirect_valid  in  1  flush and restart at redirect_pc.
- redirect_pc  in  16  new fetch address.

## Operation
- States: FETCH_OP, FETCH_CB, FETCH_LO, FETCH_HI, PRESENT.
- FETCH_OP: request at pc. On ack, latch op_pc=pc and pc+=1. Byte 0xCB → FETCH_CB. Length-2 → FETCH_LO. Length-3 → FETCH_LO. Otherwise → PRESENT.
- FETCH_CB: on ack, opcode=byte, op_cb=1, op_len=2, pc+=1 → PRESENT.
- FETCH_LO: on ack, op_imm[7:0]=byte, pc+=1. Length-3 → FETCH_HI; else → PRESENT.
- FETCH_HI: on ack, op_imm[15:8]=byte, pc+=1 → PRESENT.
- Length-2 opcodes: 06,0E,16,1E,26,2E,36,3E, 10, 18,20,28,30,38, C6,CE,D6,DE,E6,EE,F6,FE, E0,F0,E8,F8.
- Length-3 opcodes: 01,11,21,31, 08, C2,C3,C4,CA,CC,CD,D2,D4,DA,DC, EA,FA.
- All other opcodes, including illegal ones, are length 1.
- PRESENT: op_valid=1 and bundle is stable until op_valid&&op_ready. On handshake → FETCH_OP, and op_valid drops next cycle.
- pc arithmetic is 16-bit modulo: 0xFFFF+1=0x0000. A 3-byte instruction at 0xFFFE takes its high immediate from 0x0000.
- Redirect, any state: pc=redirect_pc, op_valid=0 next cycle, state → FETCH_OP.
  - If a request is outstanding (mem_req=1 and no ack this cycle), the request is kept until ack and that byte is discarded via a drop flag. The new request is issued the cycle after the discarded ack.
  - Redirect in the same cycle as a handshake: the handshake counts as consumed and the redirect still applies.
  - Redirect in the same cycle as an ack with no drop needed: the acked byte is discarded.
- Reset mid-operation: all state abandoned; the outstanding bus cycle is not completed.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, op_valid=0, opcode=0, op_cb=0, op_imm=0, op_len=0, op_pc=0, op_illegal=0. State=FETCH_OP, pc=RESET_PC.
- mem_req asserts the first cycle after reset release.
- With zero-wait memory (ack in request cycle), op_valid rises N cycles after the first request for an N-byte instruction.
- Minimum issue rate without prefetch: one bundle per N+1 cycles.
- Wait states stretch the corresponding fetch state one cycle each.

## Configuration
- FETCH_PREFETCH_EN defined:
  - In PRESENT, the unit requests the byte at pc into a 1-byte prefetch buffer, which is valid on ack.
  - After handshake, FETCH_OP consumes a valid buffer without a bus access.
  - Issue rate for back-to-back 1-byte instructions: one per cycle.
  - Redirect invalidates the buffer.
- Undefined: no bus activity in PRESENT; mem_req=0 there.

## Structure
- Shared package gb_cpu_pkg:
  - fetch state enum;
  - CB_PREFIX=8'hCB;
  - op_len encoding;
  - illegal-opcode constants.
- Sub-module opcode_len_lut: combinational, 8-bit opcode in, 2-bit length and illegal flag out. The decoder may reuse it.

## Test plan
- Zero-wait ROM 00,00,3E,42,C3,34,12, op_ready=1: bundles (00,len1,pc0000), (00,len1,pc0001), (3E,imm0042,len2,pc0002), (C3,imm1234,len3,pc0004).
- CB 37 at 0x0100: opcode=37, op_cb=1, op_len=2, op_pc=0100.
- op_ready=0 for 5 cycles in PRESENT: bundle held stable, no handshake. Without prefetch, mem_req=0 throughout.
- mem_ack delayed 3 cycles while redirect_valid=1 to 0x0038 at request start: stale byte dropped; next mem_addr=0038; next bundle has op_pc=0038.
- 3-byte 01 at 0xFFFE with bytes [FFFF]=34, [0000]=12: op_imm=1234, and the next fetch is at 0x0001.
- Assert rst_n low during FETCH_HI: all outputs return to reset values immediately. Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/gb_cpu_pkg.sv
// -----------------------------------------------------------------------------
// gb_cpu_pkg
//
// Definitions shared across the SM83 core front end. These include the fetch
// state enum, the CB prefix byte, the encoding of instruction length, and the
// table of unprefixed opcodes that have no defined behaviour.
// -----------------------------------------------------------------------------
package gb_cpu_pkg;

    // States of the fetch sequencer.
    typedef enum logic [2:0] {
        FETCH_OP = 3'd0,    // fetch the opcode byte (or the 0xCB prefix)
        FETCH_CB = 3'd1,    // fetch the opcode byte that follows 0xCB
        FETCH_LO = 3'd2,    // fetch the low immediate byte
        FETCH_HI = 3'd3,    // fetch the high immediate byte
        PRESENT  = 3'd4     // hold the bundle until the decoder accepts it
    } fetch_state_e;

    localparam logic [7:0] CB_PREFIX = 8'hCB;

    // Instruction length in bytes. The value 0 appears only out of reset,
    // before any bundle has been assembled.
    typedef logic [1:0] op_len_t;
    localparam op_len_t OP_LEN_NONE = 2'd0;
    localparam op_len_t OP_LEN_1    = 2'd1;
    localparam op_len_t OP_LEN_2    = 2'd2;
    localparam op_len_t OP_LEN_3    = 2'd3;

    // Unprefixed opcodes with no defined behaviour, packed eight bits per entry.
    localparam int NUM_ILLEGAL_OPS = 11;
    localparam logic [8*NUM_ILLEGAL_OPS-1:0] ILLEGAL_OPS = {
        8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
        8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD
    };

    function automatic logic is_illegal_op(input logic [7:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_ILLEGAL_OPS; i++) begin
            if (ILLEGAL_OPS[8*i +: 8] == op) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/fetch_unit_opcode_len_lut.sv
// -----------------------------------------------------------------------------
// opcode_len_lut
//
// Combinational classifier for unprefixed SM83 opcodes. The decoder can
// reuse it.
//
// Ports:
//   op_i       in  8  opcode byte (unprefixed opcode space)
//   len_o      out 2  total instruction length in bytes (1..3)
//   illegal_o  out 1  opcode has no defined behaviour
//
// The 0xCB prefix reports length 1. The fetch unit handles the prefix itself.
// -----------------------------------------------------------------------------
module opcode_len_lut
    import gb_cpu_pkg::*;
(
    input  logic [7:0] op_i,
    output op_len_t    len_o,
    output logic       illegal_o
);

    always_comb begin
        len_o = OP_LEN_1;
        case (op_i)
            // LD r,d8
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            // STOP, JR, JR cc
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            // ALU A,d8
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            // LDH, ADD SP,r8, LD HL,SP+r8
            8'hE0, 8'hF0, 8'hE8, 8'hF8:
                len_o = OP_LEN_2;
            // LD rr,d16, LD (a16),SP
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            // JP / CALL (conditional and unconditional)
            8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
            8'hD2, 8'hD4, 8'hDA, 8'hDC,
            // LD (a16),A / LD A,(a16)
            8'hEA, 8'hFA:
                len_o = OP_LEN_3;
            default:
                len_o = OP_LEN_1;
        endcase
    end

    assign illegal_o = is_illegal_op(op_i);

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// SM83 instruction fetch stage. It reads bytes at the program counter and
// resolves the 0xCB prefix. It gathers 8- and 16-bit immediates, then
// presents one complete instruction bundle to the decoder over a valid/ready
// handshake. Execute redirects the fetch address for jumps, calls, returns
// and interrupt vectors.
//
// Configuration macro: FETCH_PREFETCH_EN
//   When defined, the unit requests the next byte into a 1-byte buffer while
//   a bundle waits in PRESENT. A 1-byte instruction found in that buffer at
//   handshake time is presented on the very next cycle.
//   When undefined, the bus is idle in PRESENT.
//
// Ports:
//   clk             in   1   core clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   mem_req         out  1   byte read request, held with mem_addr until ack
//   mem_addr        out  16  read address
//   mem_ack         in   1   read completes this cycle
//   mem_rdata       in   8   read data, valid with mem_ack
//   op_valid        out  1   instruction bundle valid
//   op_ready        in   1   decoder accepts the bundle
//   opcode          out  8   opcode (the byte after 0xCB for prefixed ops)
//   op_cb           out  1   instruction is CB-prefixed
//   op_imm          out  16  immediate, little-endian; 8-bit in [7:0]
//   op_len          out  2   total instruction length in bytes
//   op_pc           out  16  address of the first instruction byte
//   op_illegal      out  1   unprefixed opcode with no defined behaviour
//   redirect_valid  in   1   flush and restart at redirect_pc
//   redirect_pc     in   16  new fetch address
// -----------------------------------------------------------------------------
module fetch_unit
    import gb_cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [7:0]  opcode,
    output logic        op_cb,
    output logic [15:0] op_imm,
    output logic [1:0]  op_len,
    output logic [15:0] op_pc,
    output logic        op_illegal,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;

    // This bit holds the bus quiet during the reset cycle itself. The first
    // request goes out on the cycle after reset is released.
    logic         started_q;

    // A redirect can arrive while a bus read is still outstanding. In that
    // case the read runs to completion at its original address, and its data
    // is thrown away.
    logic         drop_q, drop_d;
    logic [15:0]  drop_addr_q, drop_addr_d;

    // Bundle registers
    logic [7:0]   opcode_q, opcode_d;
    logic         op_cb_q, op_cb_d;
    logic [15:0]  op_imm_q, op_imm_d;
    op_len_t      op_len_q, op_len_d;
    logic [15:0]  op_pc_q, op_pc_d;
    logic         op_illegal_q, op_illegal_d;

    logic         bus_want;     // the sequencer wants a byte at pc_q
    logic         byte_ack;     // live (non-dropped) byte arrives this cycle
    logic         pf_hit;       // opcode byte comes from the prefetch buffer
    logic [7:0]   op_byte;      // candidate opcode byte
    logic         load_op;      // capture op_byte as a new instruction start
    op_len_t      lut_len;
    logic         lut_illegal;

`ifdef FETCH_PREFETCH_EN
    logic         pf_valid_q, pf_valid_d;
    logic [7:0]   pf_data_q, pf_data_d;

    // A request is wanted in every state, PRESENT included, unless the
    // buffer already holds the next byte.
    assign bus_want = started_q && !pf_valid_q;
    assign pf_hit   = pf_valid_q;
    assign op_byte  = pf_valid_q ? pf_data_q : mem_rdata;
`else
    assign bus_want = started_q && (state_q != PRESENT);
    assign pf_hit   = 1'b0;
    assign op_byte  = mem_rdata;
`endif

    assign mem_req  = drop_q || bus_want;
    assign mem_addr = drop_q ? drop_addr_q : pc_q;
    assign byte_ack = mem_ack && bus_want && !drop_q;

    opcode_len_lut u_len_lut (
        .op_i      (op_byte),
        .len_o     (lut_len),
        .illegal_o (lut_illegal)
    );

    // ------------------------------------------------------------------
    // Next-state and bundle assembly
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        drop_addr_d  = drop_addr_q;
        opcode_d     = opcode_q;
        op_cb_d      = op_cb_q;
        op_imm_d     = op_imm_q;
        op_len_d     = op_len_q;
        op_pc_d      = op_pc_q;
        op_illegal_d = op_illegal_q;
        load_op      = 1'b0;
`ifdef FETCH_PREFETCH_EN
        pf_valid_d   = pf_valid_q;
        pf_data_d    = pf_data_q;
`endif

        // The discarded read has completed, so the bus is free again.
        if (drop_q && mem_ack) begin
            drop_d = 1'b0;
        end

        case (state_q)
            FETCH_OP: begin
                if (byte_ack || pf_hit) begin
                    load_op = 1'b1;
                end
            end
            FETCH_CB: begin
                if (byte_ack) begin
                    opcode_d     = mem_rdata;
                    op_cb_d      = 1'b1;
                    op_len_d     = OP_LEN_2;
                    // The whole CB-prefixed opcode space is defined.
                    op_illegal_d = 1'b0;
                    pc_d         = pc_q + 16'd1;
                    state_d      = PRESENT;
                end
            end
            FETCH_LO: begin
                if (byte_ack) begin
                    op_imm_d = {8'h00, mem_rdata};
                    pc_d     = pc_q + 16'd1;
                    state_d  = (op_len_q == OP_LEN_3) ? FETCH_HI : PRESENT;
                end
            end
            FETCH_HI: begin
                if (byte_ack) begin
                    op_imm_d = {mem_rdata, op_imm_q[7:0]};
                    pc_d     = pc_q + 16'd1;
                    state_d  = PRESENT;
                end
            end
            PRESENT: begin
                if (op_ready) begin
                    state_d = FETCH_OP;
`ifdef FETCH_PREFETCH_EN
                    // If the next opcode byte is already here, start on it
                    // at once. This lets 1-byte instructions issue back to
                    // back.
                    if (pf_valid_q || byte_ack) begin
                        load_op = 1'b1;
                    end
                    pf_valid_d = 1'b0;
                end else if (byte_ack) begin
                    pf_valid_d = 1'b1;
                    pf_data_d  = mem_rdata;
`endif
                end
            end
            default: begin
                state_d = FETCH_OP;
            end
        endcase

        if (load_op) begin
            op_pc_d      = pc_q;
            pc_d         = pc_q + 16'd1;
            opcode_d     = op_byte;
            op_cb_d      = 1'b0;
            op_imm_d     = 16'h0000;
            op_len_d     = lut_len;
            op_illegal_d = lut_illegal;
            if (op_byte == CB_PREFIX) begin
                state_d = FETCH_CB;
            end else if (lut_len != OP_LEN_1) begin
                state_d = FETCH_LO;
            end else begin
                state_d = PRESENT;
            end
        end

        // A redirect overrides everything above. Any byte acked this cycle
        // is ignored, because the state returns to FETCH_OP at the new pc.
        if (redirect_valid) begin
            state_d = FETCH_OP;
            pc_d    = redirect_pc;
`ifdef FETCH_PREFETCH_EN
            pf_valid_d = 1'b0;
`endif
            if (mem_req && !mem_ack) begin
                drop_d      = 1'b1;
                drop_addr_d = mem_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH_OP;
            pc_q         <= RESET_PC;
            started_q    <= 1'b0;
            drop_q       <= 1'b0;
            drop_addr_q  <= RESET_PC;
            opcode_q     <= 8'h00;
            op_cb_q      <= 1'b0;
            op_imm_q     <= 16'h0000;
            op_len_q     <= OP_LEN_NONE;
            op_pc_q      <= 16'h0000;
            op_illegal_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            started_q    <= 1'b1;
            drop_q       <= drop_d;
            drop_addr_q  <= drop_addr_d;
            opcode_q     <= opcode_d;
            op_cb_q      <= op_cb_d;
            op_imm_q     <= op_imm_d;
            op_len_q     <= op_len_d;
            op_pc_q      <= op_pc_d;
            op_illegal_q <= op_illegal_d;
        end
    end

`ifdef FETCH_PREFETCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_valid_q <= 1'b0;
            pf_data_q  <= 8'h00;
        end else begin
            pf_valid_q <= pf_valid_d;
            pf_data_q  <= pf_data_d;
        end
    end
`endif

    assign op_valid   = (state_q == PRESENT);
    assign opcode     = opcode_q;
    assign op_cb      = op_cb_q;
    assign op_imm     = op_imm_q;
    assign op_len     = op_len_q;
    assign op_pc      = op_pc_q;
    assign op_illegal = op_illegal_q;

endmodule
